// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM state type and pointer-width helper for the AXI arbiters
package axi_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axi_ar_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   i_req  request vector, bit i = requester i
//   i_ptr  index where the scan starts (wraps at MasterCount-1 -> 0)
//   o_gnt  one-hot grant, zero when no request
//   o_idx  index of the granted requester
//   o_any  at least one request present
module rr_pick import axi_arb_pkg::*; #(
  parameter int MasterCount = 2,
  parameter int PtrW = ptr_width(MasterCount)
) (
  input  logic [MasterCount-1:0] i_req,
  input  logic [PtrW-1:0]        i_ptr,
  output logic [MasterCount-1:0] o_gnt,
  output logic [PtrW-1:0]        o_idx,
  output logic                   o_any
);
  logic [PtrW-1:0] w_j;
  // Scan from the farthest offset back to i_ptr so the nearest request wins.
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int i = MasterCount - 1; i >= 0; i--) begin
      w_j = PtrW'((int'(i_ptr) + i) % MasterCount);
      if (i_req[w_j]) o_idx = w_j;
    end
  end
  assign o_any = |i_req;
  assign o_gnt = o_any ? (MasterCount'(1) << o_idx) : '0;
endmodule

// File: rtl/axi_ar_arbiter.sv
// axi_ar_arbiter: round-robin AR/R arbiter sharing one slave read port among masters
//   ACLK, ARESETn  clock, asynchronous active-low reset
//   ARVALID_in     per-master ARVALID
//   ARREADY_s      ARREADY from the selected slave
//   RVALID_s, RREADY_s, RLAST_s  R handshake of the granted burst
//   ARsel_out      one-hot AR grant, held while in ADDR
//   ARVALID_out    granted master's ARVALID, forwarded while in ADDR
//   RSEL_out       one-hot R route, held while in DATA
//   busy           high whenever a transaction is held
module axi_ar_arbiter import axi_arb_pkg::*; #(
  parameter int MasterCount = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [MasterCount-1:0] ARVALID_in,
  input  logic                   ARREADY_s,
  input  logic                   RVALID_s,
  input  logic                   RREADY_s,
  input  logic                   RLAST_s,
  output logic [MasterCount-1:0] ARsel_out,
  output logic                   ARVALID_out,
  output logic [MasterCount-1:0] RSEL_out,
  output logic                   busy
);
  localparam int PtrW = ptr_width(MasterCount);
  arb_state_t r_state, w_next;
  logic [MasterCount-1:0] r_arsel, r_rsel, w_gnt;
  logic [PtrW-1:0] r_ptr, r_idx, w_idx;
  logic w_any, w_ar_hs, w_r_done;

  rr_pick #(.MasterCount(MasterCount), .PtrW(PtrW)) u_pick (
    .i_req(ARVALID_in),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) r_state <= IDLE;
    else r_state <= w_next;

  // r_arsel is only nonzero in ADDR, so masking with it also masks by state.
  always_comb begin
    ARVALID_out = (r_state == ADDR) && |(ARVALID_in & r_arsel);
    w_ar_hs = ARVALID_out && ARREADY_s;
    w_r_done = (r_state == DATA) && RVALID_s && RREADY_s && RLAST_s;
    w_next = (r_state == IDLE && w_any) ? ADDR :
             w_ar_hs ? DATA :
             w_r_done ? IDLE : r_state;
  end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_arsel <= '0;
      r_rsel <= '0;
      r_ptr <= '0;
      r_idx <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_arsel <= w_gnt;
        r_idx <= w_idx;
      end
      if (w_ar_hs) begin
        r_rsel <= r_arsel;
        r_arsel <= '0;
      end
      // The pointer advances past the served master only once its burst ends.
      if (w_r_done) begin
        r_rsel <= '0;
        r_ptr <= (r_idx == PtrW'(MasterCount - 1)) ? '0 : r_idx + 1'b1;
      end
    end

  assign ARsel_out = r_arsel;
  assign RSEL_out = r_rsel;
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_axi_ar_arbiter.sv
// tb_axi_ar_arbiter: vector table, scoreboarded round-robin runs and reset corner case
module tb_axi_ar_arbiter;
  import axi_arb_pkg::*;
  logic clk = 1'b0;
  logic ARESETn = 1'b0;
  logic [1:0] av2 = '0;
  logic [3:0] av4 = '0;
  logic ardy = 1'b0, rv = 1'b0, rr = 1'b0, rl = 1'b0;
  logic [1:0] arsel2, rsel2;
  logic [3:0] arsel4, rsel4;
  logic arvout2, busy2, arvout4, busy4;
  int passed = 0;
  int total = 0;

  typedef struct packed {
    logic [1:0] av;
    logic ardy, rv, rr, rl;
    logic [5:0] exp;
  } vec_t;

  // exp = {ARsel_out, RSEL_out, ARVALID_out, busy}, seen before the row's clock edge
  vec_t tbl [21] = '{
    12'b10_0000_000000, 12'b10_0000_100011, 12'b10_0000_100011, 12'b10_0000_100011,
    12'b10_0000_100011, 12'b10_0000_100011, 12'b10_1000_100011, 12'b00_0101_001001,
    12'b00_0110_001001, 12'b00_0110_001001, 12'b00_0011_001001, 12'b00_0110_001001,
    12'b00_0111_001001, 12'b11_0000_000000, 12'b11_0000_010011, 12'b10_1000_010001,
    12'b11_1000_010011, 12'b10_0110_000101, 12'b10_0111_000101, 12'b10_0000_000000,
    12'b10_0000_100011
  };

  axi_ar_arbiter #(.MasterCount(2)) u_dut2 (
    .ACLK(clk), .ARESETn(ARESETn), .ARVALID_in(av2), .ARREADY_s(ardy),
    .RVALID_s(rv), .RREADY_s(rr), .RLAST_s(rl),
    .ARsel_out(arsel2), .ARVALID_out(arvout2), .RSEL_out(rsel2), .busy(busy2)
  );

  axi_ar_arbiter #(.MasterCount(4)) u_dut4 (
    .ACLK(clk), .ARESETn(ARESETn), .ARVALID_in(av4), .ARREADY_s(ardy),
    .RVALID_s(rv), .RREADY_s(rr), .RLAST_s(rl),
    .ARsel_out(arsel4), .ARVALID_out(arvout4), .RSEL_out(rsel4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pick(input logic [3:0] req, input int ptr, input int n);
    logic [3:0] t;
    for (int o = 0; o < n; o++) begin
      t = req >> ((ptr + o) % n);
      if (t[0]) return (ptr + o) % n;
    end
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    ARESETn = 1'b0;
    av2 = '0; av4 = '0; ardy = 1'b0; rv = 1'b0; rr = 1'b0; rl = 1'b0;
    @(negedge clk);
    ARESETn = 1'b1;
  endtask

  task automatic rr_run(input int n, input logic [3:0] req, input int grants);
    logic [3:0] q [$];
    logic [3:0] got;
    int ptr, j, cyc;
    do_reset();
    ptr = 0;
    for (int g = 0; g < grants; g++) begin
      j = pick(req, ptr, n);
      q.push_back(4'(1) << j);
      ptr = (j + 1) % n;
    end
    @(negedge clk);
    ardy = 1'b1; rv = 1'b1; rr = 1'b1; rl = 1'b1;
    if (n == 2) av2 = req[1:0];
    else av4 = req;
    cyc = 0;
    while (q.size() > 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = (n == 2) ? {2'b00, arsel2} : arsel4;
      if (got != 4'b0) chk($sformatf("rr%0d_grant", n), 32'(got), 32'(q.pop_front()));
    end
    if (q.size() > 0) chk("rr_timeout_pending", q.size(), 0);
    av2 = '0; av4 = '0; ardy = 1'b0; rv = 1'b0; rr = 1'b0; rl = 1'b0;
  endtask

  always @(negedge clk)
    if (ARESETn)
      chk("invariants",
          {24'b0, $onehot0(arsel2), $onehot0(rsel2), $onehot0(arsel4), $onehot0(rsel4),
           !(|arsel2 && |rsel2), !(|arsel4 && |rsel4),
           busy2 == (u_dut2.r_state != IDLE), busy4 == (u_dut4.r_state != IDLE)},
          32'hFF);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      {av2, ardy, rv, rr, rl} = {tbl[i].av, tbl[i].ardy, tbl[i].rv, tbl[i].rr, tbl[i].rl};
      #1;
      chk($sformatf("vec%0d", i), {26'b0, arsel2, rsel2, arvout2, busy2}, {26'b0, tbl[i].exp});
    end
    do_reset();
    @(negedge clk);
    av2 = 2'b10;
    @(negedge clk);
    chk("rst_grant_m1", 32'(arsel2), 32'h2);
    ardy = 1'b1;
    @(negedge clk);
    chk("rst_in_data", {29'b0, rsel2, busy2}, 32'h5);
    ardy = 1'b0; rv = 1'b1; rr = 1'b1; rl = 1'b0;
    @(negedge clk);
    rv = 1'b0; rr = 1'b0;
    #2 ARESETn = 1'b0;
    #1 chk("rst_async_clear", {26'b0, arsel2, rsel2, busy2, arvout2}, 32'h0);
    @(negedge clk);
    ARESETn = 1'b1;
    av2 = 2'b11;
    @(negedge clk);
    chk("rst_ptr_zero_grant", 32'(arsel2), 32'h1);
    av2 = 2'b00;
    rr_run(2, 4'b0011, 4);
    rr_run(4, 4'b1111, 5);
    rr_run(4, 4'b1010, 4);
    do_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
Read-channel arbiter for the AXI interconnect. It shares one slave read port between MasterCount masters.
- Selects one master's AR request using round-robin.
- Produces the one-hot master-select vector that the S2M ARREADY decoder and the AR/R muxes consume.
- Holds the grant from AR handshake until the last R beat completes.
- Sits between the master-side AR/R ports and the per-slave decode/mux logic.

Parameters:
MasterCount, 2, number of requesting masters (>=2)

Ports:
ACLK  input  1  system clock; all state updates on rising edge
ARESETn  input  1  asynchronous active-low reset
ARVALID_in  input  MasterCount  per-master ARVALID (bit i = master i)
ARREADY_s  input  1  ARREADY from selected slave
RVALID_s  input  1  RVALID from selected slave
RREADY_s  input  1  RREADY of granted master, already muxed by RSEL_out
RLAST_s  input  1  RLAST from selected slave
ARsel_out  output  MasterCount  one-hot AR-channel grant; all-zero when no grant
ARVALID_out  output  1  ARVALID forwarded to slave = ARVALID_in[granted] while in ADDR
RSEL_out  output  MasterCount  one-hot R-channel route (granted master) while in DATA
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock ACLK; reset ARESETn is asynchronous and active-low.
- Reset values (async on ARESETn low, any state, mid-burst included):
  - state=IDLE, ARsel_out=0, RSEL_out=0, busy=0, rr_ptr=0.
  - ARVALID_out=0.
  - Any in-flight transaction is abandoned; no recovery.
- State machine: IDLE, ADDR, DATA.
- IDLE:
  - If |ARVALID_in, pick the first set bit scanning from index rr_ptr upward, wrapping at MasterCount-1 -> 0.
  - Register the one-hot grant into ARsel_out and go to ADDR.
  - Latency: request visible in cycle N -> ARsel_out valid in cycle N+1. No combinational path ARVALID_in -> ARsel_out.
  - If no request, remain in IDLE with ARsel_out=0.
- ADDR:
  - ARsel_out held constant.
  - ARVALID_out = |(ARVALID_in & ARsel_out), combinational.
  - On ARVALID_out && ARREADY_s at a clock edge -> DATA.
  - Same edge: RSEL_out <= ARsel_out, ARsel_out <= 0.
  - If the granted master drops ARVALID (a protocol violation), remain in ADDR and keep the grant; no re-arbitration.
  - Requests from other masters are ignored while a grant is held.
- DATA:
  - RSEL_out held; ARVALID_out=0; ARsel_out=0.
  - On RVALID_s && RREADY_s && RLAST_s: go to IDLE, RSEL_out <= 0, rr_ptr <= (granted index + 1) mod MasterCount.
  - Non-last beats (RLAST_s=0) do not change state.
  - RVALID_s without RREADY_s: hold.
- Turnaround: a new arbitration cannot happen in the cycle DATA exits. The earliest next ARsel_out is 2 cycles after the last-beat edge (IDLE evaluates, then registers).
- rr_ptr: width $clog2(MasterCount). Updates only on DATA exit, never on reset release or in IDLE.
- Simultaneous requests: the lowest index at or above rr_ptr wins. With all masters requesting continuously, grants rotate 0,1,...,MC-1,0.
- Invariants (assert in bench):
  - ARsel_out and RSEL_out are each one-hot or zero.
  - ARsel_out and RSEL_out are never both nonzero.
  - busy == (state != IDLE).

Decomposition:
- Shared package (axi_arb_pkg):
  - enum arb_state_t {IDLE, ADDR, DATA}.
  - localparam function for the pointer width ($clog2).
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[MasterCount], ptr.
  - Outputs: one-hot gnt, index, any.
  - Reused later for the AW/W arbiter.

Test Plan:
1. Reset mid-DATA, MC=2: grant master 1, AR handshake, assert ARESETn=0 between beats -> immediately ARsel_out=0, RSEL_out=0, busy=0, ARVALID_out=0. After release, a master-0 request is granted first (rr_ptr=0).
2. Single request: ARVALID_in=2'b10 at cycle 0 -> ARsel_out=2'b10 at cycle 1. With ARREADY_s=1, at cycle 2 state=DATA and RSEL_out=2'b10. A 4-beat burst with RLAST on beat 4 -> IDLE after beat 4, rr_ptr=0.
3. Round-robin fairness: ARVALID_in=2'b11 held, 1-beat bursts -> grant sequence 01,10,01,10. At MC=4 with all requesting -> 0,1,2,3,0.
4. Slave backpressure: ARREADY_s=0 for 5 cycles in ADDR -> ARsel_out stable, ARVALID_out=1, no state change. Grant transfers to RSEL_out on the first ARREADY_s=1 edge.
5. R backpressure and non-last beats: RVALID_s=1, RREADY_s=0 with RLAST_s=1 -> stays in DATA. Beats with RLAST_s=0 -> stays in DATA. Exit only on the VALID&READY&LAST edge.
6. Grant stability: master 0 granted; master 1 asserts ARVALID during ADDR/DATA, and master 0 drops ARVALID in ADDR -> no re-arbitration, ARVALID_out=0 while dropped. Master 1 is granted 2 cycles after master 0's last beat.
